// File: rtl/fp_f2u_pipe.sv
// Two-stage float (e5 bias 15, f1.15 fraction) to 16-bit unsigned integer converter
// with a valid/ready handshake; stage 1 decodes the exponent, stage 2 shifts and flags overflow.
module fp_f2u_pipe #(
    parameter bit P_SAT_EN = 1'b1,
    parameter int P_TAG_W  = 4
) (
    input  logic               clk_core,
    input  logic               rst_x,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [20:0]        i_a,
    input  logic [P_TAG_W-1:0] i_tag,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [15:0]        o_int,
    output logic               o_ovf,
    output logic [P_TAG_W-1:0] o_tag
);

    localparam logic [1:0] CLS_ZERO = 2'd0;
    localparam logic [1:0] CLS_NORM = 2'd1;
    localparam logic [1:0] CLS_OVF  = 2'd2;

    function automatic logic [1:0] classify(input logic [4:0] e);
        if (e == 5'h1F) return CLS_OVF;
        if (e < 5'h0F) return CLS_ZERO;
        return CLS_NORM;
    endfunction

    // Right-shift distance that moves the binary point of f1.15 onto the integer LSB.
    function automatic logic [3:0] shift_amt(input logic [4:0] e);
        logic [4:0] d;
        if (e < 5'h0F) return 4'd15;
        if (e > 5'h1E) return 4'd0;
        d = 5'd30 - e;
        return d[3:0];
    endfunction

    function automatic logic [15:0] saturate(input logic [1:0] cls, input logic [15:0] shifted);
        case (cls)
            CLS_OVF:  return P_SAT_EN ? 16'hFFFF : 16'h0000;
            CLS_NORM: return shifted;
            default:  return 16'h0000;
        endcase
    endfunction

    logic               s1_v;
    logic [3:0]         s1_shift;
    logic [1:0]         s1_cls;
    logic [15:0]        s1_frac;
    logic [P_TAG_W-1:0] s1_tag;

    logic               s2_adv;
    logic               s1_adv;
    logic [15:0]        s2_shifted;

    assign s2_adv     = !o_valid || i_ready;
    assign s1_adv     = !s1_v || s2_adv;
    assign o_ready    = s1_adv;
    assign s2_shifted = s1_frac >> s1_shift;

    // Stage 1: exponent decode
    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            s1_v <= 1'b0;
        end else if (s1_adv) begin
            s1_v <= i_valid;
        end
    end

    always_ff @(posedge clk_core) begin
        if (s1_adv && i_valid) begin
            s1_shift <= shift_amt(i_a[20:16]);
            s1_cls   <= classify(i_a[20:16]);
            s1_frac  <= i_a[15:0];
            s1_tag   <= i_tag;
        end
    end

    // Stage 2: barrel shift and overflow handling, registered straight onto the outputs
    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            o_valid <= 1'b0;
            o_int   <= 16'h0000;
            o_ovf   <= 1'b0;
            o_tag   <= '0;
        end else begin
            if (s2_adv) begin
                o_valid <= s1_v;
            end
            if (s2_adv && s1_v) begin
                o_int <= saturate(s1_cls, s2_shifted);
                o_ovf <= (s1_cls == CLS_OVF);
                o_tag <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_fp_f2u_pipe.sv
// Scoreboarded bench for fp_f2u_pipe; two instances (saturating and zeroing overflow) share stimulus.
module tb_fp_f2u_pipe;

    localparam int TW = 4;

    logic          clk_core = 1'b0;
    logic          rst_x    = 1'b1;
    logic          i_valid  = 1'b0;
    logic          i_ready  = 1'b0;
    logic [20:0]   i_a      = '0;
    logic [TW-1:0] i_tag    = '0;

    logic          o_ready_s, o_valid_s, o_ovf_s;
    logic [15:0]   o_int_s;
    logic [TW-1:0] o_tag_s;
    logic          o_ready_z, o_valid_z, o_ovf_z;
    logic [15:0]   o_int_z;
    logic [TW-1:0] o_tag_z;

    fp_f2u_pipe #(.P_SAT_EN(1'b1), .P_TAG_W(TW)) dut_sat (
        .clk_core(clk_core), .rst_x(rst_x), .i_valid(i_valid), .o_ready(o_ready_s),
        .i_a(i_a), .i_tag(i_tag), .o_valid(o_valid_s), .i_ready(i_ready),
        .o_int(o_int_s), .o_ovf(o_ovf_s), .o_tag(o_tag_s)
    );

    fp_f2u_pipe #(.P_SAT_EN(1'b0), .P_TAG_W(TW)) dut_zero (
        .clk_core(clk_core), .rst_x(rst_x), .i_valid(i_valid), .o_ready(o_ready_z),
        .i_a(i_a), .i_tag(i_tag), .o_valid(o_valid_z), .i_ready(i_ready),
        .o_int(o_int_z), .o_ovf(o_ovf_z), .o_tag(o_tag_z)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic [15:0]   int_sat;
        logic [15:0]   int_zero;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_popped = 0;

    logic          snap_valid, snap_ready, snap_ovf;
    logic [15:0]   snap_int;
    logic [TW-1:0] snap_tag;

    // Value = f * 2^(e-15) / 2^15, truncated.
    function automatic exp_t model(input logic [20:0] a, input logic [TW-1:0] tag);
        exp_t r;
        longint unsigned v;
        int e;
        e     = int'(a[20:16]);
        r.tag = tag;
        if (e == 31) begin
            r.ovf      = 1'b1;
            r.int_sat  = 16'hFFFF;
            r.int_zero = 16'h0000;
        end else begin
            v          = 64'(a[15:0]);
            v          = (v << e) >> 30;
            r.ovf      = 1'b0;
            r.int_sat  = v[15:0];
            r.int_zero = v[15:0];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Output monitor: a transfer happens at the next rising edge when o_valid & i_ready.
    always @(negedge clk_core) begin
        if (rst_x) begin
            check("valid_match", 32'(o_valid_z), 32'(o_valid_s));
            check("ready_match", 32'(o_ready_z), 32'(o_ready_s));
            if (o_valid_s && i_ready) begin
                n_assert++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected_output observed=%0h expected=none", o_int_s);
                end
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    n_popped++;
                    check("int_sat",  32'(o_int_s), 32'(e.int_sat));
                    check("int_zero", 32'(o_int_z), 32'(e.int_zero));
                    check("ovf_sat",  32'(o_ovf_s), 32'(e.ovf));
                    check("ovf_zero", 32'(o_ovf_z), 32'(e.ovf));
                    check("tag",      32'(o_tag_s), 32'(e.tag));
                end
            end
        end
    end

    // One clock cycle: drive at posedge+1, sample at negedge, return at next posedge+1.
    task automatic drive_cycle(input logic v, input logic [20:0] a, input logic [TW-1:0] tag,
                               input logic rdy, output logic acc);
        i_valid = v;
        i_a     = a;
        i_tag   = tag;
        i_ready = rdy;
        @(negedge clk_core);
        snap_valid = o_valid_s;
        snap_ready = o_ready_s;
        snap_int   = o_int_s;
        snap_ovf   = o_ovf_s;
        snap_tag   = o_tag_s;
        acc = i_valid && o_ready_s;
        if (acc) sb.push_back(model(a, tag));
        @(posedge clk_core);
        #1;
    endtask

    task automatic drain(input string name);
        logic acc;
        int k;
        k = 0;
        while (sb.size() > 0 && k < 50) begin
            drive_cycle(1'b0, '0, '0, 1'b1, acc);
            k++;
        end
        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL %s_drain observed=%0d expected=0 pending", name, sb.size());
        end
    endtask

    task automatic single_latency(input string name);
        logic acc;
        drive_cycle(1'b1, {5'h14, 16'hC000}, 4'd3, 1'b1, acc);
        check({name, "_acc"}, 32'(acc), 32'd1);
        check({name, "_c0"}, 32'(snap_valid), 32'd0);
        drive_cycle(1'b0, '0, '0, 1'b1, acc);
        check({name, "_c1"}, 32'(snap_valid), 32'd0);
        drive_cycle(1'b0, '0, '0, 1'b1, acc);
        check({name, "_c2"}, 32'(snap_valid), 32'd1);
        check({name, "_int"}, 32'(snap_int), 32'd48);
        check({name, "_ovf"}, 32'(snap_ovf), 32'd0);
        check({name, "_tag"}, 32'(snap_tag), 32'd3);
        drive_cycle(1'b0, '0, '0, 1'b1, acc);
        check({name, "_c3"}, 32'(snap_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic [20:0]   vec [8];
        logic [20:0]   bnd [5];
        logic [15:0]   held_int;
        logic [TW-1:0] held_tag;
        int            idx;
        int            pops0;
        int            accepted;

        // Reset state
        #2 rst_x = 1'b0;
        #1;
        check("rst_valid", 32'(o_valid_s), 32'd0);
        check("rst_int",   32'(o_int_s),   32'd0);
        check("rst_ovf",   32'(o_ovf_s),   32'd0);
        check("rst_tag",   32'(o_tag_s),   32'd0);
        repeat (3) @(posedge clk_core);
        #3 rst_x = 1'b1;
        @(posedge clk_core);
        #1;

        single_latency("single");

        // Boundary sweep plus overflow, back-to-back
        bnd[0] = {5'h0E, 16'h8000};
        bnd[1] = {5'h0F, 16'h8000};
        bnd[2] = {5'h1E, 16'hFFFF};
        bnd[3] = {5'h00, 16'h0000};
        bnd[4] = {5'h1F, 16'h8000};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, bnd[i], TW'(i + 1), 1'b1, acc);
            check("bnd_acc", 32'(acc), 32'd1);
        end
        drain("bnd");

        // Backpressure: i_ready low for the first 5 cycles of an 8-item burst
        for (int i = 0; i < 8; i++) vec[i] = {5'($urandom_range(15, 30)), 16'($urandom)};
        idx   = 0;
        pops0 = n_popped;
        for (int cyc = 0; cyc < 40 && (idx < 8 || sb.size() > 0); cyc++) begin
            drive_cycle(idx < 8, vec[idx < 8 ? idx : 0], TW'(idx), cyc >= 5, acc);
            if (cyc < 2) check("bp_ready_early", 32'(snap_ready), 32'd1);
            if (cyc >= 2 && cyc < 5) begin
                check("bp_ready_held", 32'(snap_ready), 32'd0);
                check("bp_valid_held", 32'(snap_valid), 32'd1);
            end
            if (cyc == 2) begin
                held_int = snap_int;
                held_tag = snap_tag;
            end
            if (cyc == 3 || cyc == 4) begin
                check("bp_int_stable", 32'(snap_int), 32'(held_int));
                check("bp_tag_stable", 32'(snap_tag), 32'(held_tag));
            end
            if (acc) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd8);
        check("bp_emitted", 32'(n_popped - pops0), 32'd8);
        drain("bp");

        // Random handshake toggling
        accepted = 0;
        pops0    = n_popped;
        for (int cyc = 0; cyc < 20000 && accepted < 1000; cyc++) begin
            drive_cycle($urandom_range(0, 3) != 0, {5'($urandom_range(0, 31)), 16'($urandom)},
                        TW'($urandom), $urandom_range(0, 3) != 0, acc);
            if (acc) accepted++;
        end
        check("rnd_accepted", 32'(accepted), 32'd1000);
        drain("rnd");
        check("rnd_emitted", 32'(n_popped - pops0), 32'd1000);

        // Asynchronous reset with both stages full
        drive_cycle(1'b1, {5'h1E, 16'h1234}, 4'd7, 1'b0, acc);
        drive_cycle(1'b1, {5'h1D, 16'h5678}, 4'd8, 1'b0, acc);
        drive_cycle(1'b0, '0, '0, 1'b0, acc);
        check("full_valid", 32'(snap_valid), 32'd1);
        check("full_ready", 32'(snap_ready), 32'd0);
        #2 rst_x = 1'b0;
        #1;
        check("arst_valid_s", 32'(o_valid_s), 32'd0);
        check("arst_valid_z", 32'(o_valid_z), 32'd0);
        check("arst_int",     32'(o_int_s),   32'd0);
        check("arst_tag",     32'(o_tag_s),   32'd0);
        sb.delete();
        #2 rst_x = 1'b1;
        @(posedge clk_core);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b1, acc);
            check("post_rst_idle", 32'(snap_valid), 32'd0);
        end
        single_latency("post_rst");
        drain("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_f2u_pipe.md
Name: fp_f2u_pipe

Overview:
- Pipelined float-to-unsigned-integer converter for the renderer's 21-bit float format: e5 exponent (bias 15) plus 16-bit f1.15 fraction with an explicit leading bit.
- Sits directly downstream of the floor stage. It consumes floored coordinates and produces 16-bit integer texel/pixel addresses with an overflow flag.
- Two register stages with a valid/ready handshake. Stalls propagate backward without dropping or duplicating data.

Parameters:
- P_SAT_EN, 1: when 1, overflow saturates the result to 16'hFFFF; when 0, overflow forces the result to 16'h0000.
- P_TAG_W, 4: width of the sideband tag carried alongside each datum.

Ports:
- clk_core  in  1  core clock; all state updates on the rising edge.
- rst_x  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream datum valid.
- o_ready  out  1  this block can accept a datum this cycle.
- i_a  in  21  input float: [20:16] exponent, [15:0] f1.15 fraction.
- i_tag  in  P_TAG_W  sideband; travels with the datum unchanged.
- o_valid  out  1  output datum valid.
- i_ready  in  1  downstream accepts the datum this cycle.
- o_int  out  16  unsigned integer result.
- o_ovf  out  1  input exponent exceeded the representable range.
- o_tag  out  P_TAG_W  tag of the output datum.

Behaviour:
- Reset: while rst_x=0, all stage valids clear and o_valid=0, o_int=0, o_ovf=0, o_tag=0. Reset asserted mid-transfer discards in-flight data; no partial output appears after release.
- Arithmetic, with e=i_a[20:16] and f=i_a[15:0]:
  - e<5'h0F: result 0, ovf=0.
  - 5'h0F<=e<=5'h1E: result = f >> (30-e), truncating fractional bits; ovf=0.
  - e=5'h1F: ovf=1, result = P_SAT_EN ? 16'hFFFF : 16'h0000.
  - Applying floor upstream does not change the result.
- Stage 1 registers: valid s1_v, shift amount (4 bits, 30-e clamped to 0..15), class (zero/normal/ovf), fraction, tag.
- Stage 2 registers: the barrel-shifted result, ovf and tag. These drive o_int, o_ovf and o_tag directly, with no combinational logic after the flops.
- Advance rules:
  - s2_adv = !o_valid | i_ready.
  - s1_adv = !s1_v | s2_adv.
  - o_ready = s1_adv (combinational from i_ready).
- Transfers:
  - Input accepted when i_valid & o_ready.
  - Stage 2 loads stage 1 when s2_adv, and o_valid <= s1_v.
  - Stage 1 loads the input when s1_adv, and s1_v <= i_valid.
- Latency and throughput: 2 cycles from acceptance to o_valid with no stall. One datum per cycle at full throughput.
- Stall: while o_valid=1 and i_ready=0, o_int, o_ovf and o_tag hold stable and o_valid stays 1. Stage 1 still fills if it is empty; o_ready=0 once both stages are full.
- Simultaneous accept and emit in one cycle: both happen, and occupancy is unchanged.
- Payload registers hold their value when their valid is 0. Only the valid bits are reset-critical, but payload outputs also reset to 0.
- i_valid deasserting mid-stream creates bubbles; bubbles never emit o_valid=1.

Test Plan:
- Reset then single datum i_a={5'h14,16'hC000}, tag 3, i_ready=1 -> o_valid pulses exactly 2 cycles after accept with o_int=48, o_ovf=0, o_tag=3.
- Boundary sweep with i_ready=1:
  - {5'h0E,16'h8000} -> 0
  - {5'h0F,16'h8000} -> 1
  - {5'h1E,16'hFFFF} -> 65535
  - {5'h00,16'h0000} -> 0
  - all with ovf=0
- Overflow: {5'h1F,16'h8000} -> o_int=16'hFFFF, o_ovf=1 with P_SAT_EN=1; o_int=0, o_ovf=1 with P_SAT_EN=0.
- Backpressure: stream 8 back-to-back values, hold i_ready=0 for 5 cycles mid-stream -> o_ready drops after 2 accepts, output stable during the hold, all 8 results emitted in order with no loss or duplication.
- Random i_valid/i_ready toggling over 1000 transfers against a reference model -> every output matches, order preserved, tags match.
- Assert rst_x low with both stages full -> o_valid=0 immediately (asynchronous). After release no stale output appears; the next input emits after 2 cycles.
